// File: rtl/cnt_bits_seq.sv
// cnt_bits_seq
// ------------
// Sequential population counter. Counts the bits of an IN-bit word that equal
// ACT, handling CHUNK bits per clock so that wide words never need a
// single-cycle adder tree. A word is accepted with a valid/ready handshake. It
// is counted over NCHUNK cycles. The result is then held until the consumer
// takes it.
//
// Optional feature: define CNT_BITS_SEQ_ACC_EN to build a saturating running
// accumulator of all delivered results. When the macro is not defined, acc and
// acc_ovf are tied to zero and acc_clr is ignored.
//
// Parameters:
//   IN     input word width
//   CHUNK  bits counted per cycle
//   ACT    bit value that is counted
//   ACCW   accumulator width
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   producer has a word
//   in_ready   block is idle and can accept a word
//   in         word to count
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out        count result, held stable while out_valid is high
//   busy       block is not idle
//   acc_clr    synchronous accumulator clear
//   acc        running sum of delivered results
//   acc_ovf    sticky flag, set when the accumulator saturates
module cnt_bits_seq #(
  parameter int   IN    = 32,
  parameter int   CHUNK = 8,
  parameter logic ACT   = 1'b1,
  parameter int   ACCW  = 16,
  localparam int  OUT   = $clog2(IN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN-1:0]   in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUT-1:0]  out,
  output logic            busy,
  input  logic            acc_clr,
  output logic [ACCW-1:0] acc,
  output logic            acc_ovf
);

  localparam int NCHUNK = (IN + CHUNK - 1) / CHUNK;
  localparam int TOTW   = NCHUNK * CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CNT  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [TOTW-1:0] shreg;
  logic [TOTW-1:0] padded;
  logic [OUT-1:0]  sum;
  logic [OUT-1:0]  chunk_cnt;
  logic [OUT-1:0]  sum_next;
  logic [CW-1:0]   idx;
  logic            last_chunk;

  // The handshake flags come straight from the state register. They have no
  // combinational path from in_valid or out_ready.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // When IN is not a multiple of CHUNK, the last chunk is filled with ~ACT.
  // Those filler bits can then never add to the count.
  always_comb begin
    padded         = {TOTW{~ACT}};
    padded[IN-1:0] = in;
  end

  // Count the ACT-valued bits in the lowest chunk of the shift register.
  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_cnt = chunk_cnt + OUT'(shreg[i] == ACT);
    end
  end

  assign sum_next   = sum + chunk_cnt;
  assign last_chunk = (idx == CW'(NCHUNK - 1));

  // Main FSM. The result register is loaded with the final partial sum in
  // the same cycle that the last chunk is added. This makes out_valid rise
  // exactly NCHUNK edges after the word is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      shreg <= '0;
      sum   <= '0;
      idx   <= '0;
      out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg <= padded;
            sum   <= '0;
            idx   <= '0;
            state <= S_CNT;
          end
        end
        S_CNT: begin
          shreg <= shreg >> CHUNK;
          sum   <= sum_next;
          idx   <= idx + CW'(1);
          if (last_chunk) begin
            out   <= sum_next;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CNT_BITS_SEQ_ACC_EN
  localparam int AW1 = ACCW + 1;

  logic           handshake;
  logic [AW1-1:0] acc_sum;

  assign handshake = out_valid && out_ready;
  assign acc_sum   = AW1'(acc) + AW1'(out);

  // Saturating accumulator. A clear that coincides with a handshake restarts
  // the sum from the result being delivered, so that result is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (acc_clr && handshake) begin
      acc     <= ACCW'(out);
      acc_ovf <= 1'b0;
    end else if (acc_clr) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (handshake) begin
      if (acc_sum[ACCW]) begin
        acc     <= '1;
        acc_ovf <= 1'b1;
      end else begin
        acc <= acc_sum[ACCW-1:0];
      end
    end
  end
`else
  logic unused_acc_clr;

  assign acc            = '0;
  assign acc_ovf        = 1'b0;
  assign unused_acc_clr = acc_clr;
`endif

endmodule

// File: tb/tb_cnt_bits_seq.sv
// tb_cnt_bits_seq
// ---------------
// Testbench for cnt_bits_seq. It builds several instances with different
// (IN, CHUNK, ACT, ACCW) settings. Each instance is driven independently, and
// every result is compared with a reference count computed straight from the
// word. Accumulator expectations follow CNT_BITS_SEQ_ACC_EN.
module tb_cnt_bits_seq;

  localparam int NI = 6;

`ifdef CNT_BITS_SEQ_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  // Instance table:
  //   0: 32/8  ACT=1
  //   1: 20/8  ACT=0 (padding)
  //   2: 5/1
  //   3: 5/5
  //   4: 33/4
  //   5: 32/8 with ACCW=6
  function automatic int cfg_in(int g);
    case (g)
      0: return 32;
      1: return 20;
      2: return 5;
      3: return 5;
      4: return 33;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_ch(int g);
    case (g)
      2: return 1;
      3: return 5;
      4: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_act(int g);
    return (g == 1) ? 0 : 1;
  endfunction

  function automatic int cfg_accw(int g);
    return (g == 5) ? 6 : 16;
  endfunction

  logic clk;
  logic reset;
  logic [NI-1:0]        in_valid;
  logic [NI-1:0]        out_ready;
  logic [NI-1:0]        acc_clr;
  logic [NI-1:0][32:0]  word;
  logic [NI-1:0]        in_ready;
  logic [NI-1:0]        out_valid;
  logic [NI-1:0]        busy;
  logic [NI-1:0]        acc_ovf;
  logic [NI-1:0][5:0]   outv;
  logic [NI-1:0][15:0]  accv;

  int n_tests = 0;
  int n_fail  = 0;

  int acc_m [NI];
  bit ovf_m [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int IW = cfg_in(g);
    localparam int OW = $clog2(IW) + 1;
    localparam int AW = cfg_accw(g);
    logic [OW-1:0] o;
    logic [AW-1:0] a;
    cnt_bits_seq #(
      .IN   (IW),
      .CHUNK(cfg_ch(g)),
      .ACT  (cfg_act(g) == 1),
      .ACCW (AW)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in       (word[g][IW-1:0]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out      (o),
      .busy     (busy[g]),
      .acc_clr  (acc_clr[g]),
      .acc      (a),
      .acc_ovf  (acc_ovf[g])
    );
    assign outv[g] = 6'(o);
    assign accv[g] = 16'(a);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference population count, taken directly over the meaningful bits.
  function automatic int ref_count(logic [32:0] w, int n, int act);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (int'(w[i]) == act) c++;
    end
    return c;
  endfunction

  function automatic int nchunk_of(int g);
    return (cfg_in(g) + cfg_ch(g) - 1) / cfg_ch(g);
  endfunction

  function automatic int exp_acc(int g);
    return ACC_ON ? acc_m[g] : 0;
  endfunction

  function automatic bit exp_ovf(int g);
    return ACC_ON ? ovf_m[g] : 1'b0;
  endfunction

  // Accumulator model for one delivered result.
  function automatic void model_acc(int g, int res, bit clr);
    int maxv = (1 << cfg_accw(g)) - 1;
    if (clr) begin
      acc_m[g] = res;
      ovf_m[g] = 1'b0;
    end else if (acc_m[g] + res > maxv) begin
      acc_m[g] = maxv;
      ovf_m[g] = 1'b1;
    end else begin
      acc_m[g] = acc_m[g] + res;
    end
  endfunction

  // Drives one word through instance g and reports what it observed.
  // During the stall, in_valid is pulsed to confirm that it is ignored.
  // flow_ok drops if out moves, out_valid falls, or in_ready rises during the
  // stall. It also drops if the block has not returned to idle after the
  // handshake.
  task automatic run_word(input int g, input logic [32:0] w, input int stall,
                          input bit clr, output logic [5:0] res,
                          output int lat, output bit flow_ok);
    @(negedge clk);
    word[g]     = w;
    in_valid[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[g] = 1'b0;
    lat = 0;
    while (!out_valid[g] && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    res     = outv[g];
    flow_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      word[g]     = 33'({$urandom, $urandom});
      in_valid[g] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (outv[g] !== res || out_valid[g] !== 1'b1 || in_ready[g] !== 1'b0)
        flow_ok = 1'b0;
    end
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b1;
    acc_clr[g]   = clr;
    @(posedge clk);
    @(negedge clk);
    out_ready[g] = 1'b0;
    acc_clr[g]   = 1'b0;
    if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0 || busy[g] !== 1'b0)
      flow_ok = 1'b0;
    model_acc(g, int'(res), clr);
  endtask

  task automatic clear_acc(input int g);
    @(negedge clk);
    acc_clr[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_clr[g] = 1'b0;
    acc_m[g]   = 0;
    ovf_m[g]   = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    acc_clr   = '0;
    word      = '0;
    for (int g = 0; g < NI; g++) begin
      acc_m[g] = 0;
      ovf_m[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (in_ready !== {NI{1'b1}}) begin
      n_fail++;
      $display("[TB] FAIL reset_in_ready: got %b expected all ones", in_ready);
    end
    n_tests++;
    if (out_valid !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_tests++;
    if (busy !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    n_tests++;
    if (outv !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_out: got %h expected 0", outv);
    end
    n_tests++;
    if (accv !== '0 || acc_ovf !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_acc: got %h/%b expected 0", accv, acc_ovf);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count32();
    logic [5:0] res;
    int lat;
    bit ok;
    run_word(0, 33'h0FFFF_FFFF, 0, 1'b0, res, lat, ok);
    n_tests++;
    if (res !== 6'd32 || lat != 4 || !ok) begin
      n_fail++;
      $display("[TB] FAIL count_all_ones: got %0d lat %0d flow %0d expected 32 lat 4 flow 1",
               res, lat, ok);
    end
    run_word(0, 33'h08000_0001, 0, 1'b0, res, lat, ok);
    n_tests++;
    if (res !== 6'd2 || lat != 4 || !ok) begin
      n_fail++;
      $display("[TB] FAIL count_ends: got %0d lat %0d flow %0d expected 2 lat 4 flow 1",
               res, lat, ok);
    end
  endtask

  task automatic test_padding();
    logic [32:0] w [3];
    int expv [3];
    logic [5:0] res;
    int lat;
    bit ok;
    w[0] = 33'h00000;  expv[0] = 20;
    w[1] = 33'hFFFFF;  expv[1] = 0;
    w[2] = 33'hF0F0F;  expv[2] = 8;
    for (int k = 0; k < 3; k++) begin
      run_word(1, w[k], 0, 1'b0, res, lat, ok);
      n_tests++;
      if (res !== 6'(expv[k]) || lat != 3 || !ok) begin
        n_fail++;
        $display("[TB] FAIL padding_%0d: got %0d lat %0d flow %0d expected %0d lat 3 flow 1",
                 k, res, lat, ok, expv[k]);
      end
    end
  endtask

  task automatic test_stall();
    logic [5:0] res;
    int lat;
    bit ok;
    run_word(0, 33'h00F0F_0F0F, 5, 1'b0, res, lat, ok);
    n_tests++;
    if (res !== 6'd16 || lat != 4 || !ok) begin
      n_fail++;
      $display("[TB] FAIL stall_hold: got %0d lat %0d flow %0d expected 16 lat 4 flow 1",
               res, lat, ok);
    end
    run_word(0, 33'h7, 0, 1'b0, res, lat, ok);
    n_tests++;
    if (res !== 6'd3 || lat != 4 || !ok) begin
      n_fail++;
      $display("[TB] FAIL stall_next: got %0d lat %0d flow %0d expected 3 lat 4 flow 1",
               res, lat, ok);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] res;
    int lat;
    bit ok;
    @(negedge clk);
    word[0]     = 33'h0FFFF_FFFF;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      acc_m[g] = 0;
      ovf_m[g] = 1'b0;
    end
    n_tests++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
        outv[0] !== 6'd0 || accv[0] !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: got valid %b busy %b ready %b out %0d acc %0d expected 0 0 1 0 0",
               out_valid[0], busy[0], in_ready[0], outv[0], accv[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    run_word(0, 33'hF, 0, 1'b0, res, lat, ok);
    n_tests++;
    if (res !== 6'd4 || lat != 4 || !ok) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_next: got %0d lat %0d flow %0d expected 4 lat 4 flow 1",
               res, lat, ok);
    end
  endtask

  task automatic test_accumulator();
    logic [5:0] res;
    int lat;
    bit ok;
    clear_acc(0);
    run_word(0, 33'h0000_00FF, 0, 1'b0, res, lat, ok);
    run_word(0, 33'h0000_FFFF, 0, 1'b0, res, lat, ok);
    run_word(0, 33'h0FFFF_FFFF, 0, 1'b0, res, lat, ok);
    n_tests++;
    if (accv[0] !== 16'(ACC_ON ? 56 : 0) || acc_ovf[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL acc_sum: got %0d ovf %b expected %0d ovf 0",
               accv[0], acc_ovf[0], ACC_ON ? 56 : 0);
    end
    run_word(0, 33'h1F, 0, 1'b1, res, lat, ok);
    n_tests++;
    if (accv[0] !== 16'(ACC_ON ? 5 : 0) || acc_ovf[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL acc_clr_hs: got %0d ovf %b expected %0d ovf 0",
               accv[0], acc_ovf[0], ACC_ON ? 5 : 0);
    end
    clear_acc(5);
    run_word(5, 33'h0FFFF_FFFF, 0, 1'b0, res, lat, ok);
    n_tests++;
    if (accv[5] !== 16'(ACC_ON ? 32 : 0) || acc_ovf[5] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL acc_sat_first: got %0d ovf %b expected %0d ovf 0",
               accv[5], acc_ovf[5], ACC_ON ? 32 : 0);
    end
    run_word(5, 33'h0FFFF_FFFF, 0, 1'b0, res, lat, ok);
    n_tests++;
    if (accv[5] !== 16'(ACC_ON ? 63 : 0) || acc_ovf[5] !== ACC_ON) begin
      n_fail++;
      $display("[TB] FAIL acc_sat: got %0d ovf %b expected %0d ovf %0d",
               accv[5], acc_ovf[5], ACC_ON ? 63 : 0, ACC_ON);
    end
    clear_acc(5);
    n_tests++;
    if (accv[5] !== 16'd0 || acc_ovf[5] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL acc_clr_alone: got %0d ovf %b expected 0 ovf 0",
               accv[5], acc_ovf[5]);
    end
  endtask

  task automatic test_random();
    int ids [4];
    logic [32:0] w;
    logic [5:0] res;
    int lat;
    int expc;
    bit ok;
    ids[0] = 2; ids[1] = 3; ids[2] = 0; ids[3] = 4;
    for (int k = 0; k < 4; k++) begin
      int g = ids[k];
      for (int n = 0; n < 250; n++) begin
        w = 33'({$urandom, $urandom});
        run_word(g, w, int'($urandom_range(0, 3)), 1'b0, res, lat, ok);
        expc = ref_count(w, cfg_in(g), cfg_act(g));
        n_tests++;
        if (res !== 6'(expc) || lat != nchunk_of(g) || !ok) begin
          n_fail++;
          $display("[TB] FAIL random_u%0d_%0d: word %h got %0d lat %0d flow %0d expected %0d lat %0d flow 1",
                   g, n, w, res, lat, ok, expc, nchunk_of(g));
        end
        n_tests++;
        if (accv[g] !== 16'(exp_acc(g)) || acc_ovf[g] !== exp_ovf(g)) begin
          n_fail++;
          $display("[TB] FAIL random_acc_u%0d_%0d: got %0d ovf %b expected %0d ovf %0d",
                   g, n, accv[g], acc_ovf[g], exp_acc(g), exp_ovf(g));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count32();
    test_padding();
    test_stall();
    test_reset_mid();
    test_accumulator();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_bits_seq.md
# cnt_bits_seq

Sequential, chunked population counter: counts bits of an `IN`-bit word equal to `ACT`, processing `CHUNK` bits per cycle so wide words do not need a single-cycle adder tree. It is the multi-cycle, handshaked successor of the combinational bit counter. It sits between a producer with valid/ready flow control and a consumer that may stall. An optional running accumulator sums successive results.

## Interface
- `IN`, 32, input word width (>= 1)
- `CHUNK`, 8, bits counted per cycle (1..`IN`)
- `ACT`, `` `High ``, bit value that is counted
- `ACCW`, 16, accumulator width (>= `OUT`)
- derived localparams: `OUT` = `$clog2(IN)+1`; `NCHUNK` = ceil(`IN`/`CHUNK`)

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `in_valid` in 1: input word valid
- `in_ready` out 1: block can accept a word
- `in` in `IN`: word to count
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `out` out `OUT`: count result
- `busy` out 1: state != IDLE
- `acc_clr` in 1: synchronous accumulator clear
- `acc` out `ACCW`: running sum of results
- `acc_ovf` out 1: sticky saturation flag

## Operation
- FSM states: IDLE, CNT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in` into the shift register, clear the partial sum and chunk counter, go to CNT.
- CNT:
  - Each cycle, add the count of `ACT`-valued bits in the low `CHUNK` bits of the shift register to the partial sum.
  - Then shift right by `CHUNK` and increment the chunk counter.
  - After `NCHUNK` cycles, load `out` and go to DONE.
- Padding: when `IN` % `CHUNK` != 0, bits beyond `IN` are filled with `~ACT` and are never counted.
- DONE:
  - `out_valid`=1; `out` is held stable.
  - On `out_ready`: go to IDLE and update the accumulator.
  - `in_valid` is ignored outside IDLE.
- Width: the partial sum is `OUT` bits wide and cannot overflow, since its maximum is `IN`.
- Accumulator (when enabled):
  - On the output handshake, `acc` <= sat(`acc` + `out`).
  - Saturation value is 2^`ACCW`-1. Saturating sets `acc_ovf`.
  - `acc_clr` alone: `acc`=0 and `acc_ovf`=0.
  - `acc_clr` together with a handshake: `acc` = `out`, and `acc_ovf` is cleared.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out`=0, `busy`=0, `acc`=0, `acc_ovf`=0.
- Input accepted at edge T -> `out_valid` rises after edge T+`NCHUNK`.
- The output handshake at edge H returns the FSM to IDLE. `in_ready`=1 after edge H, so the next word can be accepted at edge H+1.
- Best-case period: `NCHUNK`+2 cycles per word with `in_valid` and `out_ready` held high.
- All outputs are registered. `in_ready` and `out_valid` are decoded from the state register, with no combinational path from `in_valid` or `out_ready`.
- Reset mid-operation (any state): the count in flight is discarded and all outputs return to their reset values immediately. Normal operation resumes on the first edge after deassertion.

## Configuration
- Macro: `CNT_BITS_SEQ_ACC_EN`.
- Defined: accumulator and saturation logic are built as described above.
- Undefined: no accumulator registers are built. `acc` is tied to 0, `acc_ovf` is tied to 0, `acc_clr` is ignored. Ports remain present, so the bench is shared across both builds.

## Test plan
- `IN`=32, `CHUNK`=8, `ACT`=1; `in`=0xFFFF_FFFF accepted at edge 0 -> `out_valid`=1 after edge 4, `out`=32; `in`=0x8000_0001 -> `out`=2.
- `IN`=20, `CHUNK`=8, `ACT`=0 (padding case); `in`=0x00000 -> `out`=20; `in`=0xFFFFF -> `out`=0; `in`=0xF0F0F -> `out`=8.
- Output stall: `out_ready`=0 for 5 cycles after `out_valid` -> `out` held, `in_ready`=0, `in_valid` pulses ignored. Release stall -> IDLE next cycle, next word counted correctly.
- Reset asserted 2 cycles into CNT with `in`=0xFFFF_FFFF -> `out_valid`=0, `busy`=0, `in_ready`=1 at once. Next word 0x0000_000F -> `out`=4.
- Accumulator with `CNT_BITS_SEQ_ACC_EN`:
  - Results 8, 16, 32 -> `acc`=56.
  - `acc_clr` on the same cycle as a handshake of result 5 -> `acc`=5.
  - `ACCW`=6, results 32 then 32 -> `acc`=63, `acc_ovf`=1.
  - Without the macro -> `acc`=0 and `acc_ovf`=0 throughout.
- Randomised: 1000 random words for (`IN`,`CHUNK`) in {(5,1),(5,5),(32,8),(33,4)} with random `out_ready` stalls -> each `out` equals a reference count of bits == `ACT`, with latency exactly `NCHUNK`.
